pipe_stage_skid: RTL and testbench

//  Generic, parametrised inter-stage pipeline register that replaces the per-stage hand-written
//  IF/ID, ID/EX, EX/DM and DM/WB latches. Carries a packed WIDTH-bit payload with a valid/ready

---
 rtl/pipe_stage_skid_pkg.sv | 16 +
 rtl/pipe_stage_skid_sat_counter.sv | 22 ++
 rtl/pipe_stage_skid.sv | 86 ++++++++
 tb/tb_pipe_stage_skid.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_skid_pkg.sv
// Shared definitions for the skid-buffered pipeline stage: occupancy states
// and a helper that decides whether a state presents a payload downstream.
package pipe_stage_skid_pkg;

  typedef enum logic [1:0] {
    PIPE_ST_EMPTY = 2'd0,
    PIPE_ST_BUSY  = 2'd1,
    PIPE_ST_FULL  = 2'd2
  } pipe_st_e;

  // The unused encoding 2'd3 counts as empty so a corrupted state never presents data.
  function automatic logic st_has_data(input pipe_st_e st);
    return (st == PIPE_ST_BUSY) || (st == PIPE_ST_FULL);
  endfunction

endpackage

// File: rtl/pipe_stage_skid_sat_counter.sv
// Saturating up-counter with synchronous active-low clear, used for
// performance-debug event counts such as backpressure cycles.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Generic inter-stage pipeline register: valid/ready handshake with a
// two-entry skid buffer, flush-to-bubble and a backpressure cycle counter.
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_DATA = '0,
  parameter int               CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] stall_cnt
);

  pipe_st_e         state_p1;
  logic [WIDTH-1:0] main_p1;
  logic [WIDTH-1:0] skid_p1;
  logic             in_fire;
  logic             out_fire;
  logic             stall;

  // in_ready depends on registered state only, never on out_ready or in_valid.
  assign in_ready  = rst && (state_p1 != PIPE_ST_FULL);
  assign out_valid = st_has_data(state_p1);
  assign out_data  = main_p1;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign stall     = out_valid && !out_ready;

  // Stage register: main holds the presented payload, skid absorbs one extra.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_p1 <= PIPE_ST_EMPTY;
      main_p1  <= RESET_DATA;
      skid_p1  <= RESET_DATA;
    end else if (flush) begin
      state_p1 <= PIPE_ST_EMPTY;
      main_p1  <= RESET_DATA;
      skid_p1  <= RESET_DATA;
    end else begin
      case (state_p1)
        PIPE_ST_BUSY: begin
          if (in_fire && out_fire) begin
            main_p1 <= in_data;
          end else if (in_fire) begin
            state_p1 <= PIPE_ST_FULL;
            skid_p1  <= in_data;
          end else if (out_fire) begin
            state_p1 <= PIPE_ST_EMPTY;
          end
        end
        PIPE_ST_FULL: begin
          if (out_fire) begin
            state_p1 <= PIPE_ST_BUSY;
            main_p1  <= skid_p1;
          end
        end
        default: begin
          if (in_fire) begin
            state_p1 <= PIPE_ST_BUSY;
            main_p1  <= in_data;
          end else begin
            state_p1 <= PIPE_ST_EMPTY;
          end
        end
      endcase
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk(clk),
    .rst(rst),
    .inc(stall),
    .cnt(stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed scenarios with hand-computed values plus
// a randomized handshake run checked by a queue-based scoreboard and counter model.
module tb_pipe_stage_skid;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [3:0]  stall_cnt;

  int          checks = 0;
  int          failures = 0;
  bit          mon_en = 1'b0;
  logic [31:0] sb[$];
  logic [3:0]  exp_cnt = 4'h0;
  bit          stalled = 1'b0;
  logic [31:0] held = 32'h0;
  logic        r0;

  pipe_stage_skid #(
    .WIDTH(32),
    .RESET_DATA(32'h0),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares flags, counter and popped payloads at mid-cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("out_valid_model", 32'(out_valid), 32'(sb.size() > 0));
      chk("in_ready_model", 32'(in_ready), 32'(rst && (sb.size() < 2)));
      chk("stall_cnt_model", 32'(stall_cnt), 32'(exp_cnt));
      if (stalled && out_valid) chk("held_stable", out_data, held);
      if (rst && out_valid && out_ready && (sb.size() > 0)) chk("out_order", out_data, sb.pop_front());
      stalled = rst && !flush && out_valid && !out_ready;
      held    = out_data;
      if (!rst) exp_cnt = 4'h0;
      else if (out_valid && !out_ready && (exp_cnt != 4'hF)) exp_cnt = exp_cnt + 4'h1;
      if (!rst || flush) sb.delete();
    end
  end

  // Issue tracker: every accepted payload becomes an expected output.
  always @(negedge clk) begin
    if (mon_en) begin
      #2;
      if (rst && !flush && in_valid && in_ready) sb.push_back(in_data);
    end
  end

  initial begin
    // Reset with junk on the input
    rst = 1'b0; in_valid = 1'b1; in_data = 32'hDEAD; out_ready = 1'b0;
    tick();
    mon_en = 1'b1;
    tick();
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_stall_cnt", 32'(stall_cnt), 32'h0);
    rst = 1'b1; in_valid = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'h1);

    // Streaming 1..4
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_data = 32'(i);
      tick();
      #2;
      chk("stream_valid", 32'(out_valid), 32'h1);
      chk("stream_data", out_data, 32'(i));
      chk("stream_in_ready", 32'(in_ready), 32'h1);
    end
    in_valid = 1'b0;
    tick();
    #2;
    chk("stream_drained", 32'(out_valid), 32'h0);
    chk("stream_stall_cnt", 32'(stall_cnt), 32'h0);

    // Skid fill and drain
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA;
    tick();
    in_data = 32'hB;
    #2;
    chk("skid_busy_in_ready", 32'(in_ready), 32'h1);
    chk("skid_busy_data", out_data, 32'hA);
    tick();
    in_valid = 1'b0;
    #2;
    chk("skid_full_in_ready", 32'(in_ready), 32'h0);
    chk("skid_full_data", out_data, 32'hA);
    chk("skid_full_valid", 32'(out_valid), 32'h1);
    tick();
    #2;
    chk("skid_hold_data", out_data, 32'hA);
    out_ready = 1'b1;
    tick();
    #2;
    chk("skid_second_data", out_data, 32'hB);
    chk("skid_in_ready_back", 32'(in_ready), 32'h1);
    tick();
    #2;
    chk("skid_empty", 32'(out_valid), 32'h0);
    chk("skid_stall_cnt", 32'(stall_cnt), 32'h2);

    // Flush while full, with a competing input and a same-cycle consume
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h11;
    tick();
    in_data = 32'h22;
    tick();
    #2;
    chk("flush_pre_full", 32'(in_ready), 32'h0);
    in_data = 32'hC; flush = 1'b1; out_ready = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #2;
    chk("flush_out_valid", 32'(out_valid), 32'h0);
    chk("flush_out_data", out_data, 32'h0);
    chk("flush_stall_cnt", 32'(stall_cnt), 32'h3);
    tick();
    #2;
    chk("flush_no_c", out_data, 32'h0);
    chk("flush_still_empty", 32'(out_valid), 32'h0);

    // Counter saturation
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h55;
    tick();
    in_valid = 1'b0;
    repeat (20) tick();
    #2;
    chk("sat_reach", 32'(stall_cnt), 32'hF);
    chk("sat_data_held", out_data, 32'h55);
    repeat (2) tick();
    chk("sat_stay", 32'(stall_cnt), 32'hF);
    out_ready = 1'b1;
    repeat (2) tick();

    // Randomized handshake with occasional flush and mid-run reset
    for (int n = 0; n < 10000; n++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      rst       = ($urandom_range(0, 299) != 0);
      #1;
      r0 = in_ready;
      out_ready = ~out_ready; in_valid = ~in_valid;
      #1;
      chk("in_ready_no_comb", 32'(in_ready), 32'(r0));
      out_ready = ~out_ready; in_valid = ~in_valid;
      tick();
    end

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) tick();
    chk("final_drain", 32'(sb.size()), 32'h0);
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
